mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Main-memory controller on the CPU's external memory bus, downstream of the instruction/data cache arbiter.
- Accepts one read or write request at a time and services it from an on-chip word-organised RAM.
- Returns data and a one-cycle acknowledge after a programmable access latency, so the arbiter and stage stall paths see realistic memory timing.
- Flags out-of-range accesses.

Parameters:
- ADDR_W, 12, word-address width; RAM holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to mem_ack. Legal range 1..15.
- INIT_FILE, "", hex file loaded into the RAM at elaboration. Empty means no preload.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- mem_read  input  1  read request, held by requester until mem_ack
- mem_write  input  1  write request, held by requester until mem_ack
- mem_addr  input  32  byte address; bits [1:0] ignored
- mem_write_data  input  32  write data, stable while mem_write is high
- mem_ack  output  1  one-cycle completion pulse
- mem_read_data  output  32  read data, valid in the mem_ack cycle
- busy  output  1  high while a request is in service
- addr_err  output  1  one-cycle pulse, coincident with mem_ack, for an out-of-range access

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: state IDLE, mem_ack=0, busy=0, addr_err=0, mem_read_data=0, latency counter=0. RAM contents are not cleared by reset.
- Word index: mem_addr[ADDR_W+1:2].
- Out-of-range access: any of mem_addr[31:ADDR_W+2] nonzero.
- State machine, IDLE -> BUSY -> ACK -> IDLE:
  - IDLE: if mem_write or mem_read is sampled high, latch address, write data and op type; load cnt=LATENCY-1; set busy=1; go to BUSY. If LATENCY=1, go straight to ACK.
  - BUSY: decrement cnt; when cnt=1 on an edge, go to ACK. Total: request sampled at edge E, mem_ack high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - ACK state register update, on the edge entering ACK:
    - Write: RAM[idx] <= latched data, unless out of range (dropped).
    - Read: mem_read_data <= RAM[idx], or 0 if out of range.
  - ACK outputs: mem_ack=1 and addr_err=(out of range) for exactly one cycle, then IDLE. busy=0 from the edge leaving ACK.
- mem_read_data holds its value until the next read completes. Writes do not alter it.
- Inputs are latched at acceptance. Changes on mem_addr, mem_write_data or the request lines during BUSY/ACK are ignored.
- Requests are not accepted in BUSY or ACK. The requester must deassert in the cycle after mem_ack, so a request still high in IDLE after ACK is serviced again as a new request.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately following ACK. Minimum request-to-request period is LATENCY+1 cycles.
- Simultaneous mem_read and mem_write in IDLE: write is serviced, read is ignored, and no ack is issued for the read.
- Reset mid-operation (BUSY or ACK) returns to IDLE immediately. A pending write not yet committed is discarded. A write committed on the edge entering ACK persists. No mem_ack is issued for an aborted request.
- RAM: single port, synchronous write, read registered into mem_read_data; must infer block RAM.

Test Plan:
- Reset then read of address 0x00000010 with RAM[4]=0xDEADBEEF, LATENCY=2 -> mem_ack high exactly 2 cycles after acceptance for 1 cycle, mem_read_data=0xDEADBEEF, busy high for 2 cycles, addr_err=0.
- Write 0x12345678 to 0x00000020, then read 0x00000022 -> write ack after LATENCY cycles; read returns 0x12345678 (low bits ignored); mem_read_data unchanged between the two acks.
- Read of 0x00010000 with ADDR_W=12 -> mem_ack and addr_err pulse together, mem_read_data=0. Write to the same address -> addr_err pulse, RAM[0] unchanged.
- mem_read and mem_write both high with data 0xA5A5A5A5 at 0x4 -> single ack; RAM[1]=0xA5A5A5A5; mem_read_data retains its previous value.
- Reset asserted in the first BUSY cycle of a write to 0x8 (LATENCY=3) -> no mem_ack, busy=0 the cycle after reset, RAM[2] unchanged. A following read completes normally.
- LATENCY=1: back-to-back reads of 0x0 and 0x4 with the request dropped one cycle after each ack -> acks exactly 2 cycles apart, data correct for each, no duplicate ack.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory controller behind the cache arbiter.
// It services one read or write at a time from an on-chip word RAM. After a
// programmable latency it returns a one-cycle acknowledge. Accesses outside
// the RAM are flagged and have no effect on the RAM.
//
// Parameters:
//   ADDR_W    word-address width; the RAM holds 2**ADDR_W 32-bit words
//   LATENCY   cycles from request acceptance to mem_ack (1..15)
//   INIT_FILE hex file preloaded into the RAM; empty means no preload
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   mem_read       read request, held until mem_ack
//   mem_write      write request, held until mem_ack (wins over mem_read)
//   mem_addr       byte address; bits [1:0] ignored
//   mem_write_data write data
//   mem_ack        one-cycle completion pulse
//   mem_read_data  read data; holds until the next read completes
//   busy           high while a request is in service
//   addr_err       one-cycle pulse with mem_ack for an out-of-range access
module mem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic        mem_ack,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        addr_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              oor_q;
  logic              write_q;
  logic [31:0]       wdata_q;

  logic [31:0] ram [2**ADDR_W];

  // The byte-offset bits are deliberately ignored.
  logic unused_byte_offset;
  assign unused_byte_offset = ^mem_addr[1:0];

  logic              req;
  logic [ADDR_W-1:0] in_idx;
  logic              in_oor;
  assign req    = mem_read | mem_write;
  assign in_idx = mem_addr[ADDR_W+1:2];
  assign in_oor = |mem_addr[31:ADDR_W+2];

  // With LATENCY=1 the commit happens on the accepting edge, before the
  // latches hold anything. In IDLE the live inputs feed the operation;
  // in every other state the latched copy does.
  logic              in_idle;
  logic [ADDR_W-1:0] op_idx;
  logic              op_oor;
  logic              op_write;
  logic [31:0]       op_wdata;
  assign in_idle  = (state == S_IDLE);
  assign op_idx   = in_idle ? in_idx         : idx_q;
  assign op_oor   = in_idle ? in_oor         : oor_q;
  assign op_write = in_idle ? mem_write      : write_q;
  assign op_wdata = in_idle ? mem_write_data : wdata_q;

  // enter_ack marks the edge on which the access commits and ACK begins.
  logic enter_ack;
  assign enter_ack = (in_idle && req && (LATENCY == 1)) ||
                     ((state == S_BUSY) && (cnt == 4'd1));

  // Control path.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mem_ack  <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      mem_ack  <= enter_ack;
      addr_err <= enter_ack & op_oor;
      case (state)
        S_IDLE: begin
          if (req) begin
            cnt  <= LAT_M1;
            busy <= 1'b1;
            if (LATENCY == 1) state <= S_ACK;
            else              state <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Request latches. These are pure datapath, so they need no reset. A write
  // wins over a simultaneous read.
  always_ff @(posedge clk) begin
    if (in_idle && req) begin
      idx_q   <= in_idx;
      oor_q   <= in_oor;
      write_q <= mem_write;
      wdata_q <= mem_write_data;
    end
  end

  // NOTE: the RAM array has no reset. Clearing it would prevent block-RAM
  // inference, and its contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (!reset && enter_ack && op_write && !op_oor) ram[op_idx] <= op_wdata;
  end

  // Registered read port. An out-of-range read returns zero. Writes leave
  // this register untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_data <= '0;
    end else if (enter_ack && !op_write) begin
      mem_read_data <= op_oor ? '0 : ram[op_idx];
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl. It uses three instances on one clock:
// LATENCY=2 for the main function, LATENCY=3 for the mid-operation reset
// and LATENCY=1 for back-to-back traffic. Each request pushes its expected
// completion onto a scoreboard queue. A monitor pops and compares an entry on
// every mem_ack.
module tb_mem_ctrl;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset          [3];
  logic        mem_read       [3];
  logic        mem_write      [3];
  logic [31:0] mem_addr       [3];
  logic [31:0] mem_write_data [3];
  logic        mem_ack        [3];
  logic [31:0] mem_read_data  [3];
  logic        busy           [3];
  logic        addr_err       [3];

  int          lat_of [3] = '{2, 3, 1};
  logic [31:0] model  [3][4096];
  logic [31:0] last_rd[3];
  exp_t        sb[$];

  int passed = 0;
  int total  = 0;

  mem_ctrl #(.ADDR_W(12), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]), .mem_ack(mem_ack[0]),
    .mem_read_data(mem_read_data[0]), .busy(busy[0]), .addr_err(addr_err[0]));

  mem_ctrl #(.ADDR_W(12), .LATENCY(3)) dut1 (
    .clk(clk), .reset(reset[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]), .mem_ack(mem_ack[1]),
    .mem_read_data(mem_read_data[1]), .busy(busy[1]), .addr_err(addr_err[1]));

  mem_ctrl #(.ADDR_W(12), .LATENCY(1)) dut2 (
    .clk(clk), .reset(reset[2]), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .mem_addr(mem_addr[2]), .mem_write_data(mem_write_data[2]), .mem_ack(mem_ack[2]),
    .mem_read_data(mem_read_data[2]), .busy(busy[2]), .addr_err(addr_err[2]));

  // Scoreboard monitor. Acks are sampled on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_ack[k] === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_ack: dut%0d acked with no request outstanding", k);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.dut != k || mem_read_data[k] !== e.rdata || addr_err[k] !== e.err)
            $display("FAIL ack_result: dut%0d data=%08h err=%b, required dut%0d data=%08h err=%b",
                     k, mem_read_data[k], addr_err[k], e.dut, e.rdata, e.err);
          else passed++;
        end
      end
    end
  end

  // Issues one request and pushes its expected completion. It then waits,
  // with a bound, for mem_ack. After acceptance the address and data are
  // scrambled to prove they were latched. The request is dropped one cycle
  // after the ack.
  task automatic do_req(input int d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int busy_n,
                        output logic ack_after, output logic busy_after);
    exp_t        e;
    logic        oor;
    logic [11:0] idx;
    oor   = |addr[31:14];
    idx   = addr[13:2];
    e.dut = d;
    e.err = oor;
    if (wr) begin
      if (!oor) model[d][idx] = wdata;
      e.rdata = last_rd[d];
    end else begin
      e.rdata    = oor ? 32'h0 : model[d][idx];
      last_rd[d] = e.rdata;
    end
    sb.push_back(e);
    mem_read[d]       = rd;
    mem_write[d]      = wr;
    mem_addr[d]       = addr;
    mem_write_data[d] = wdata;
    lat    = -1;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        mem_addr[d]       = ~addr;
        mem_write_data[d] = ~wdata;
      end
      if (busy[d] === 1'b1) busy_n++;
      if (mem_ack[d] === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0 && sb.size() > 0) e = sb.pop_back();
    @(posedge clk); #1;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    ack_after    = mem_ack[d];
    busy_after   = busy[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      reset[d] = 1'b1; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      mem_addr[d] = '0; mem_write_data[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (mem_ack[d] !== 1'b0 || busy[d] !== 1'b0 || addr_err[d] !== 1'b0 || mem_read_data[d] !== 32'h0)
        $display("FAIL reset_state: dut%0d ack=%b busy=%b err=%b data=%08h, required 0 0 0 00000000",
                 d, mem_ack[d], busy[d], addr_err[d], mem_read_data[d]);
      else passed++;
    end
  endtask

  task automatic test_read_basic();
    int lat, bn; logic aa, ba;
    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, bn, aa, ba);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, bn, aa, ba);
    total++;
    if (lat != 2) $display("FAIL read_latency: got %0d cycles, required 2", lat); else passed++;
    total++;
    if (bn != 2) $display("FAIL read_busy_cycles: got %0d, required 2", bn); else passed++;
    total++;
    if (aa !== 1'b0 || ba !== 1'b0)
      $display("FAIL read_after_ack: ack=%b busy=%b, required 0 0", aa, ba);
    else passed++;
  endtask

  task automatic test_write_read();
    int lat, bn; logic aa, ba;
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h12345678, lat, bn, aa, ba);
    total++;
    if (lat != 2) $display("FAIL write_latency: got %0d cycles, required 2", lat); else passed++;
    total++;
    if (mem_read_data[0] !== 32'hDEADBEEF)
      $display("FAIL write_keeps_rdata: got %08h, required deadbeef", mem_read_data[0]);
    else passed++;
    do_req(0, 1'b1, 1'b0, 32'h22, 32'h0, lat, bn, aa, ba);
    total++;
    if (lat != 2) $display("FAIL read_low_bits_latency: got %0d cycles, required 2", lat); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat, bn; logic aa, ba;
    do_req(0, 1'b0, 1'b1, 32'h0, 32'h11111111, lat, bn, aa, ba);
    do_req(0, 1'b1, 1'b0, 32'h00010000, 32'h0, lat, bn, aa, ba);
    total++;
    if (lat != 2) $display("FAIL oor_read_latency: got %0d cycles, required 2", lat); else passed++;
    do_req(0, 1'b0, 1'b1, 32'h00010000, 32'h99999999, lat, bn, aa, ba);
    total++;
    if (aa !== 1'b0 || addr_err[0] !== 1'b0)
      $display("FAIL oor_err_pulse_width: ack=%b err=%b after ack cycle, required 0 0", aa, addr_err[0]);
    else passed++;
    // Reads RAM[0] back. The scoreboard still expects 11111111.
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, bn, aa, ba);
  endtask

  task automatic test_simultaneous();
    int lat, bn; logic aa, ba;
    do_req(0, 1'b1, 1'b1, 32'h4, 32'hA5A5A5A5, lat, bn, aa, ba);
    total++;
    if (lat != 2) $display("FAIL simul_latency: got %0d cycles, required 2", lat); else passed++;
    repeat (3) @(posedge clk);
    #1;
    do_req(0, 1'b1, 1'b0, 32'h4, 32'h0, lat, bn, aa, ba);
  endtask

  task automatic test_reset_mid();
    int lat, bn; logic aa, ba;
    do_req(1, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, lat, bn, aa, ba);
    do_req(1, 1'b1, 1'b0, 32'h8, 32'h0, lat, bn, aa, ba);
    mem_write[1] = 1'b1; mem_addr[1] = 32'h8; mem_write_data[1] = 32'hCAFEBABE;
    @(posedge clk); #1;
    total++;
    if (busy[1] !== 1'b1) $display("FAIL mid_accept_busy: got %b, required 1", busy[1]); else passed++;
    reset[1] = 1'b1; mem_write[1] = 1'b0;
    @(posedge clk); #1;
    reset[1]   = 1'b0;
    last_rd[1] = '0;
    total++;
    if (busy[1] !== 1'b0 || mem_ack[1] !== 1'b0 || mem_read_data[1] !== 32'h0)
      $display("FAIL mid_reset_state: busy=%b ack=%b data=%08h, required 0 0 00000000",
               busy[1], mem_ack[1], mem_read_data[1]);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    do_req(1, 1'b1, 1'b0, 32'h8, 32'h0, lat, bn, aa, ba);
    total++;
    if (lat != 3) $display("FAIL mid_reset_read_latency: got %0d cycles, required 3", lat); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bn, n_acks, t1, t2; logic aa, ba;
    exp_t e;
    do_req(2, 1'b0, 1'b1, 32'h0, 32'h01010101, lat, bn, aa, ba);
    total++;
    if (lat != 1) $display("FAIL lat1_write_latency: got %0d cycles, required 1", lat); else passed++;
    do_req(2, 1'b0, 1'b1, 32'h4, 32'h02020202, lat, bn, aa, ba);
    e.dut = 2; e.err = 1'b0;
    e.rdata = model[2][0]; sb.push_back(e);
    e.rdata = model[2][1]; sb.push_back(e);
    last_rd[2] = model[2][1];
    mem_read[2] = 1'b1; mem_addr[2] = 32'h0;
    n_acks = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (n_acks == 2 && i == t2 + 1) mem_read[2] = 1'b0;
      if (mem_ack[2] === 1'b1) begin
        n_acks++;
        if (n_acks == 1) begin
          t1 = i;
          mem_addr[2] = 32'h4;
        end else if (n_acks == 2) begin
          t2 = i;
        end
      end
    end
    mem_read[2] = 1'b0;
    total++;
    if (n_acks != 2) $display("FAIL b2b_ack_count: got %0d, required 2", n_acks); else passed++;
    total++;
    if (t2 - t1 != 2) $display("FAIL b2b_ack_spacing: got %0d cycles, required 2", t2 - t1); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained: %0d acks missing, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
